// File: rtl/diff_sd_driver.sv
// Differential first-order sigma-delta driver with break-before-make dead time on polarity changes.
// Define SD_DITHER_EN to add an 8-bit LFSR carry-in dither to the accumulator.
module diff_sd_driver #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEAD  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] code,
  input  logic             code_valid,
  output logic             code_ready,
  output logic             vip,
  output logic             vin,
  output logic             oe,
  output logic             frame_end
);

  localparam int unsigned DeadW = (DEAD > 1) ? $clog2(DEAD) : 1;
  localparam logic [DeadW-1:0] DeadInit = (DEAD > 0) ? DeadW'(DEAD - 1) : '0;

  typedef enum logic [1:0] {StIdle, StRun, StDead} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] cur_code_q, cur_code_d;
  logic [WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [DeadW-1:0] dead_cnt_q, dead_cnt_d;
  logic             last_bit_q, last_bit_d;
  logic             first_q, first_d;
  logic             vip_q, vip_d, vin_q, vin_d, oe_q, oe_d;
  logic             frame_end_q, frame_end_d;

  logic             carry_in;
  logic [WIDTH:0]   sum;
  logic             sd_bit, run_apply, dead_apply, step_apply, frame_last, accept;

`ifdef SD_DITHER_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign carry_in = lfsr_q[0];
`else
  assign carry_in = 1'b0;
`endif

  assign sum        = {1'b0, acc_q} + {1'b0, cur_code_q} + {{WIDTH{1'b0}}, carry_in};
  assign sd_bit     = sum[WIDTH];
  assign run_apply  = (state_q == StRun) & (first_q | (sd_bit == last_bit_q) | (DEAD == 0));
  // The pending step is applied on the last dead cycle so exactly DEAD zero cycles appear.
  assign dead_apply = (state_q == StDead) & (dead_cnt_q == '0);
  assign step_apply = run_apply | dead_apply;
  assign frame_last = &frame_cnt_q;
  assign code_ready = en & ((state_q == StIdle) | (step_apply & frame_last));
  assign accept     = code_valid & code_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (accept) state_d = StRun;
        StRun:   if (!run_apply) state_d = StDead;
        StDead:  if (dead_cnt_q == '0) state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    acc_d       = acc_q;
    cur_code_d  = cur_code_q;
    frame_cnt_d = frame_cnt_q;
    dead_cnt_d  = dead_cnt_q;
    last_bit_d  = last_bit_q;
    first_d     = first_q;
    vip_d       = vip_q;
    vin_d       = vin_q;
    oe_d        = oe_q;
    frame_end_d = 1'b0;
`ifdef SD_DITHER_EN
    lfsr_d      = lfsr_q;
`endif
    if (!en) begin
      acc_d       = '0;
      frame_cnt_d = '0;
      dead_cnt_d  = '0;
      first_d     = 1'b0;
      vip_d       = 1'b0;
      vin_d       = 1'b0;
      oe_d        = 1'b0;
    end else if (state_q == StIdle) begin
      vip_d = 1'b0;
      vin_d = 1'b0;
      oe_d  = 1'b0;
      if (accept) begin
        cur_code_d  = code;
        acc_d       = '0;
        frame_cnt_d = '0;
        first_d     = 1'b1;
      end
    end else if (step_apply) begin
      acc_d       = sum[WIDTH-1:0];
      vip_d       = sd_bit;
      vin_d       = ~sd_bit;
      oe_d        = 1'b1;
      last_bit_d  = sd_bit;
      frame_cnt_d = frame_cnt_q + WIDTH'(1);
      first_d     = 1'b0;
      frame_end_d = frame_last;
      if (accept) cur_code_d = code;
`ifdef SD_DITHER_EN
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
    end else if (state_q == StRun) begin
      vip_d      = 1'b0;
      vin_d      = 1'b0;
      dead_cnt_d = DeadInit;
    end else begin
      dead_cnt_d = dead_cnt_q - DeadW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cur_code_q  <= '0;
      frame_cnt_q <= '0;
      dead_cnt_q  <= '0;
      last_bit_q  <= 1'b0;
      first_q     <= 1'b0;
      vip_q       <= 1'b0;
      vin_q       <= 1'b0;
      oe_q        <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cur_code_q  <= cur_code_d;
      frame_cnt_q <= frame_cnt_d;
      dead_cnt_q  <= dead_cnt_d;
      last_bit_q  <= last_bit_d;
      first_q     <= first_d;
      vip_q       <= vip_d;
      vin_q       <= vin_d;
      oe_q        <= oe_d;
      frame_end_q <= frame_end_d;
    end
  end

`ifdef SD_DITHER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end
`endif

  assign vip       = vip_q;
  assign vin       = vin_q;
  assign oe        = oe_q;
  assign frame_end = frame_end_q;

endmodule

// File: tb/tb_diff_sd_driver.sv
// Directed bench for diff_sd_driver: one DUT with DEAD=0 and one with DEAD=2, a shared step monitor
// checking each applied step against a closed-form density pattern taken from a code scoreboard.
module tb_diff_sd_driver;

  localparam int N = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic       en0, en1, cv0, cv1;
  logic [7:0] code;
  logic       cr0, vip0, vin0, oe0, fe0;
  logic       cr1, vip1, vin1, oe1, fe1;

  always #5 clk = ~clk;

  diff_sd_driver #(.WIDTH(8), .DEAD(0)) dut0 (
    .clk(clk), .rst(rst), .en(en0), .code(code), .code_valid(cv0), .code_ready(cr0),
    .vip(vip0), .vin(vin0), .oe(oe0), .frame_end(fe0)
  );

  diff_sd_driver #(.WIDTH(8), .DEAD(2)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .code(code), .code_valid(cv1), .code_ready(cr1),
    .vip(vip1), .vin(vin1), .oe(oe1), .frame_end(fe1)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard of accepted codes; front is the code of the frame in progress.
  int   sbq[$];
  int   sel;
  bit   mon_on;
  int   k, ones, cyc, trans, zrun, fe_cnt, c, dead;
  bit   have_last, have_fe;
  logic lastb, v, n, o, f, exp_b;

  task automatic clear_mon();
    sbq.delete();
    k = 0; ones = 0; cyc = 0; trans = 0; zrun = 0;
    have_last = 0; have_fe = 0;
  endtask

  always @(negedge clk) begin
    checks++;
    assert (!(vip0 && vin0)) else begin
      errors++; $error("FAIL overlap0 observed=1 expected=0");
    end
    checks++;
    assert (!(vip1 && vin1)) else begin
      errors++; $error("FAIL overlap1 observed=1 expected=0");
    end
    if (mon_on) begin
      v    = (sel == 1) ? vip1 : vip0;
      n    = (sel == 1) ? vin1 : vin0;
      o    = (sel == 1) ? oe1 : oe0;
      f    = (sel == 1) ? fe1 : fe0;
      dead = (sel == 1) ? 2 : 0;
      cyc++;
      if (v || n) begin
        checks++;
        assert (sbq.size() > 0) else begin
          errors++; $error("FAIL sb_empty observed=0 expected=>0 entries");
        end
        c     = (sbq.size() > 0) ? sbq[0] : 0;
        exp_b = ((((k * c) % N) + c) >= N);
        checks++;
        assert (v === exp_b) else begin
          errors++; $error("FAIL step_vip k=%0d code=%0d observed=%b expected=%b", k, c, v, exp_b);
        end
        checks++;
        assert (n === !exp_b) else begin
          errors++; $error("FAIL step_vin k=%0d code=%0d observed=%b expected=%b", k, c, n, !exp_b);
        end
        if (have_last) begin
          if (lastb !== v) trans++;
          checks++;
          assert (zrun === ((lastb !== v) ? dead : 0)) else begin
            errors++; $error("FAIL dead_cycles k=%0d observed=%0d expected=%0d", k, zrun,
                             (lastb !== v) ? dead : 0);
          end
        end
        checks++;
        assert (f === (k == N - 1)) else begin
          errors++; $error("FAIL frame_end_pos k=%0d observed=%b expected=%b", k, f, (k == N - 1));
        end
        ones += int'(v);
        k++;
        have_last = 1; lastb = v; zrun = 0;
        if (f) begin
          checks++;
          assert (ones === c) else begin
            errors++; $error("FAIL frame_ones observed=%0d expected=%0d", ones, c);
          end
          if (have_fe) begin
            checks++;
            assert (cyc === N + dead * trans) else begin
              errors++; $error("FAIL frame_period observed=%0d expected=%0d", cyc, N + dead * trans);
            end
          end
          have_fe = 1; cyc = 0; trans = 0; k = 0; ones = 0;
          fe_cnt++;
          if (sbq.size() > 1) void'(sbq.pop_front());
        end
      end else begin
        if (o) zrun++;
        checks++;
        assert (f === 1'b0) else begin
          errors++; $error("FAIL fe_idle observed=%b expected=0", f);
        end
      end
    end
  end

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  task automatic accept(input int which, input logic [7:0] cv, input bit from_idle,
                        input bit mid_frame);
    bit got;
    int wait_n;
    got    = 0;
    wait_n = 0;
    code   = cv;
    if (which == 0) cv0 = 1'b1; else cv1 = 1'b1;
    for (int i = 0; i < 2000 && !got; i++) begin
      #1;
      if (((which == 0) ? cr0 : cr1) === 1'b1) begin
        got    = 1;
        wait_n = i;
        sbq.push_back(int'(cv));
      end
      @(posedge clk);
      #2;
    end
    cv0 = 1'b0;
    cv1 = 1'b0;
    checks++;
    assert (got) else begin
      errors++; $error("FAIL accept_timeout observed=no_ready expected=ready");
    end
    if (got && mid_frame) begin
      checks++;
      assert (wait_n > 0) else begin
        errors++; $error("FAIL ready_mid_frame observed=%0d expected=>0 waits", wait_n);
      end
      checks++;
      assert (fe1 === 1'b1) else begin
        errors++; $error("FAIL handshake_last_step observed=%b expected=1", fe1);
      end
    end
    if (got && from_idle) begin
      @(posedge clk);
      #1;
      checks++;
      assert (((which == 0) ? (vip0 | vin0) : (vip1 | vin1)) === 1'b1) else begin
        errors++; $error("FAIL first_step_no_dead observed=0 expected=1");
      end
      tick(1);
    end
  endtask

  task automatic wait_frames(input int nf);
    int start, cnt;
    start = fe_cnt;
    cnt   = 0;
    while (fe_cnt < start + nf && cnt < 900 * nf) begin
      tick(1);
      cnt++;
    end
    checks++;
    assert (fe_cnt >= start + nf) else begin
      errors++; $error("FAIL frame_timeout observed=%0d expected=%0d", fe_cnt - start, nf);
    end
  endtask

  task automatic restart(input int which, input logic [7:0] cv);
    en0    = 1'b0;
    en1    = 1'b0;
    mon_on = 1'b0;
    tick(1);
    #1;
    checks++;
    assert (((which == 0) ? {vip0, vin0, oe0, fe0, cr0} : {vip1, vin1, oe1, fe1, cr1}) === 5'b0)
    else begin
      errors++; $error("FAIL en_low_off inst=%0d observed=%b expected=00000", which,
                       (which == 0) ? {vip0, vin0, oe0, fe0, cr0} : {vip1, vin1, oe1, fe1, cr1});
    end
    tick(1);
    clear_mon();
    sel = which;
    if (which == 0) en0 = 1'b1; else en1 = 1'b1;
    mon_on = 1'b1;
    accept(which, cv, 1, 0);
  endtask

  initial begin
    bit found;
    rst = 1'b1; en0 = 1'b0; en1 = 1'b0; cv0 = 1'b0; cv1 = 1'b0; code = '0;
    sel = 0; mon_on = 1'b0; fe_cnt = 0;
    clear_mon();
    #23;
    checks++;
    assert ({vip0, vin0, oe0, fe0, cr0, vip1, vin1, oe1, fe1, cr1} === 10'b0) else begin
      errors++; $error("FAIL reset_outputs observed=%b expected=0",
                       {vip0, vin0, oe0, fe0, cr0, vip1, vin1, oe1, fe1, cr1});
    end
    tick(1);
    rst = 1'b0;
    tick(1);
    en0 = 1'b1;
    #1;
    checks++;
    assert (cr0 === 1'b1) else begin
      errors++; $error("FAIL idle_ready observed=%b expected=1", cr0);
    end
    tick(1);

    // DEAD=0, code 64
    sel = 0; mon_on = 1'b1;
    accept(0, 8'd64, 1, 0);
    wait_frames(3);

    // Extremes on DEAD=0
    restart(0, 8'd0);
    wait_frames(2);
    restart(0, 8'd255);
    wait_frames(2);

    // DEAD=2, alternating code
    restart(1, 8'd128);
    wait_frames(3);

    // Mid-frame code change waits for the last step
    restart(1, 8'd64);
    wait_frames(1);
    tick(100);
    accept(1, 8'd200, 0, 1);
    wait_frames(3);

    // Drop en mid-frame, then restart
    tick(37);
    restart(1, 8'd128);
    wait_frames(1);

    // Asynchronous reset during a dead cycle
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (vip1 === 1'b0 && vin1 === 1'b0 && oe1 === 1'b1) found = 1;
    end
    checks++;
    assert (found) else begin
      errors++; $error("FAIL dead_seen observed=0 expected=1");
    end
    mon_on = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    assert ({vip1, vin1, oe1, fe1} === 4'b0) else begin
      errors++; $error("FAIL async_reset observed=%b expected=0000", {vip1, vin1, oe1, fe1});
    end
    #2 rst = 1'b0;
    tick(1);
    #1;
    checks++;
    assert ({cr1, vip1, vin1, oe1} === 4'b1000) else begin
      errors++; $error("FAIL post_reset_idle observed=%b expected=1000", {cr1, vip1, vin1, oe1});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
